// File: rtl/fetch_arb.sv
// fetch_arb: round-robin owner arbitration for the shared line-fetch engine.
//
// Each requester holds a fetch request (cmd, tag, addr) until it is granted.
// One owner is picked at a time, and its payload is latched and issued to the
// engine. Ownership lasts until the engine reports done. The engine's gnt and
// done pulses are routed back to the owner only.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_fetch_req  [N]       per-requester request, held until its gnt
//   req_fetch_cmd  [2N]      per-requester cmd (00 write-back, 01 line fill)
//   req_fetch_tag  [tw*N]    per-requester line tag
//   req_fetch_addr [aw*N]    per-requester line-aligned address
//   req_fetch_gnt  [N]       one-cycle grant pulse to the owner
//   req_fetch_done [N]       one-cycle done pulse to the owner
//   eng_fetch_req/cmd/tag/addr  request and latched payload to the engine
//   eng_fetch_gnt, eng_fetch_done  engine accept / completion pulses
//   arb_busy                 high while not IDLE
//   arb_owner [ow]           current or last owner
//
// Optional build macro FETCH_ARB_PERF_EN adds:
//   perf_grant_cnt [16N]     per-requester saturating grant counts
//   perf_stall_cnt [16]      saturating count of cycles in which a non-owner
//                            waits while the arbiter is not IDLE
//
// state | meaning
// IDLE  | no owner; select a round-robin winner and latch its payload
// ISSUE | eng_fetch_req high with the latched payload until eng_fetch_gnt
// BUSY  | engine working for the owner; wait for eng_fetch_done
module fetch_arb #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int num_req    = 2,
    localparam int tw = $clog2(list_depth),
    localparam int ow = $clog2(num_req)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [num_req-1:0]         req_fetch_req,
    input  logic [2*num_req-1:0]       req_fetch_cmd,
    input  logic [tw*num_req-1:0]      req_fetch_tag,
    input  logic [addr_width*num_req-1:0] req_fetch_addr,
    output logic [num_req-1:0]         req_fetch_gnt,
    output logic [num_req-1:0]         req_fetch_done,
    output logic                       eng_fetch_req,
    output logic [1:0]                 eng_fetch_cmd,
    output logic [tw-1:0]              eng_fetch_tag,
    output logic [addr_width-1:0]      eng_fetch_addr,
    input  logic                       eng_fetch_gnt,
    input  logic                       eng_fetch_done,
    output logic                       arb_busy,
    output logic [ow-1:0]              arb_owner
`ifdef FETCH_ARB_PERF_EN
    ,
    output logic [16*num_req-1:0]      perf_grant_cnt,
    output logic [15:0]                perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [ow-1:0]        rr_ptr;
    logic [ow-1:0]        rr_ptr_nxt;
    logic [ow-1:0]        win_idx;
    logic                 win_vld;
    logic [ow-1:0]        scan_idx;
    logic [num_req-1:0]   owner_oh;

    // First set request at or above rr_ptr, wrapping.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = rr_ptr;
        scan_idx = '0;
        for (int k = 0; k < num_req; k++) begin
            scan_idx = ow'((int'(rr_ptr) + k) % num_req);
            if (!win_vld && req_fetch_req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < num_req; i++) begin
            owner_oh[i] = (arb_owner == ow'(i));
        end
    end

    assign rr_ptr_nxt = (arb_owner == ow'(num_req - 1)) ? '0 : arb_owner + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld)        state_nxt = ISSUE;
            ISSUE:   if (eng_fetch_gnt)  state_nxt = BUSY;
            BUSY:    if (eng_fetch_done) state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            arb_owner      <= '0;
            eng_fetch_cmd  <= '0;
            eng_fetch_tag  <= '0;
            eng_fetch_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_vld) begin
                arb_owner      <= win_idx;
                eng_fetch_cmd  <= req_fetch_cmd[int'(win_idx)*2 +: 2];
                eng_fetch_tag  <= req_fetch_tag[int'(win_idx)*tw +: tw];
                eng_fetch_addr <= req_fetch_addr[int'(win_idx)*addr_width +: addr_width];
            end
            if (state == BUSY && eng_fetch_done) begin
                rr_ptr <= rr_ptr_nxt;
            end
        end
    end

    // Pulses are suppressed during reset so an aborted transfer never reports done.
    assign req_fetch_gnt  = (state == ISSUE && eng_fetch_gnt  && !rst) ? owner_oh : '0;
    assign req_fetch_done = (state == BUSY  && eng_fetch_done && !rst) ? owner_oh : '0;
    assign eng_fetch_req  = (state == ISSUE);
    assign arb_busy       = (state != IDLE);

`ifdef FETCH_ARB_PERF_EN
    logic stall_now;

    assign stall_now = (state != IDLE) && ((req_fetch_req & ~owner_oh) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < num_req; i++) begin
                if (req_fetch_gnt[i] && perf_grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    perf_grant_cnt[i*16 +: 16] <= perf_grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
            if (stall_now && perf_stall_cnt != 16'hFFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_fetch_arb.sv
module tb_fetch_arb;
    localparam int AW = 32;
    localparam int LD = 4;
    localparam int NR = 3;
    localparam int TW = $clog2(LD);
    localparam int OW = $clog2(NR);

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    req_fetch_req, req_fetch_gnt, req_fetch_done;
    logic [2*NR-1:0]  req_fetch_cmd;
    logic [TW*NR-1:0] req_fetch_tag;
    logic [AW*NR-1:0] req_fetch_addr;
    logic             eng_fetch_req;
    logic [1:0]       eng_fetch_cmd;
    logic [TW-1:0]    eng_fetch_tag;
    logic [AW-1:0]    eng_fetch_addr;
    logic             eng_fetch_gnt, eng_fetch_done, arb_busy;
    logic [OW-1:0]    arb_owner;
`ifdef FETCH_ARB_PERF_EN
    logic [16*NR-1:0] perf_grant_cnt;
    logic [15:0]      perf_stall_cnt;
`endif

    logic [1:0]    p_cmd  [NR];
    logic [TW-1:0] p_tag  [NR];
    logic [AW-1:0] p_addr [NR];

    always_comb begin
        req_fetch_cmd  = '0;
        req_fetch_tag  = '0;
        req_fetch_addr = '0;
        for (int i = 0; i < NR; i++) begin
            req_fetch_cmd[2*i +: 2]    = p_cmd[i];
            req_fetch_tag[TW*i +: TW]  = p_tag[i];
            req_fetch_addr[AW*i +: AW] = p_addr[i];
        end
    end

    always #5 clk = ~clk;

    fetch_arb #(.addr_width(AW), .list_depth(LD), .num_req(NR)) dut (
        .clk(clk),
        .rst(rst),
        .req_fetch_req(req_fetch_req),
        .req_fetch_cmd(req_fetch_cmd),
        .req_fetch_tag(req_fetch_tag),
        .req_fetch_addr(req_fetch_addr),
        .req_fetch_gnt(req_fetch_gnt),
        .req_fetch_done(req_fetch_done),
        .eng_fetch_req(eng_fetch_req),
        .eng_fetch_cmd(eng_fetch_cmd),
        .eng_fetch_tag(eng_fetch_tag),
        .eng_fetch_addr(eng_fetch_addr),
        .eng_fetch_gnt(eng_fetch_gnt),
        .eng_fetch_done(eng_fetch_done),
        .arb_busy(arb_busy),
        .arb_owner(arb_owner)
`ifdef FETCH_ARB_PERF_EN
        ,
        .perf_grant_cnt(perf_grant_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction view of the arbiter.
    bit            m_active = 0;
    bit            m_acc    = 0;
    int            m_own    = 0;
    int            m_ptr    = 0;
    logic [1:0]    m_cmd    = '0;
    logic [TW-1:0] m_tag    = '0;
    logic [AW-1:0] m_addr   = '0;
    int            m_gcnt [NR];
    int            m_stall  = 0;
    logic [NR-1:0] e_gnt, e_done;
    logic          e_req, e_busy;

    task automatic model_check();
        e_req  = m_active && !m_acc;
        e_busy = m_active;
        e_gnt  = '0;
        e_done = '0;
        if (!rst && m_active && !m_acc && eng_fetch_gnt) e_gnt[m_own] = 1'b1;
        if (!rst && m_active && m_acc && eng_fetch_done) e_done[m_own] = 1'b1;
        chk("model_gnt", req_fetch_gnt, e_gnt);
        chk("model_done", req_fetch_done, e_done);
        chk("model_eng_req", eng_fetch_req, e_req);
        chk("model_busy", arb_busy, e_busy);
        chk("model_owner", arb_owner, m_own);
        chk("model_payload", {eng_fetch_cmd, eng_fetch_tag, eng_fetch_addr}, {m_cmd, m_tag, m_addr});
`ifdef FETCH_ARB_PERF_EN
        for (int i = 0; i < NR; i++) chk("model_perf_grant", perf_grant_cnt[16*i +: 16], m_gcnt[i]);
        chk("model_perf_stall", perf_stall_cnt, m_stall);
`endif
    endtask

    task automatic model_update();
        bit found;
        bit other;
        int idx;
        if (rst) begin
            m_active = 0; m_acc = 0; m_own = 0; m_ptr = 0;
            m_cmd = '0; m_tag = '0; m_addr = '0;
            for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
            m_stall = 0;
        end else begin
            other = 0;
            for (int i = 0; i < NR; i++) begin
                if (e_gnt[i] && m_gcnt[i] < 65535) m_gcnt[i]++;
                if (i != m_own && req_fetch_req[i]) other = 1;
            end
            if (m_active && other && m_stall < 65535) m_stall++;
            if (!m_active) begin
                found = 0;
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (!found && req_fetch_req[idx]) begin
                        found = 1;
                        m_own = idx;
                    end
                end
                if (found) begin
                    m_active = 1; m_acc = 0;
                    m_cmd = p_cmd[m_own]; m_tag = p_tag[m_own]; m_addr = p_addr[m_own];
                end
            end else if (!m_acc) begin
                if (eng_fetch_gnt) m_acc = 1;
            end else if (eng_fetch_done) begin
                m_active = 0;
                m_ptr = (m_own + 1) % NR;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [NR-1:0] q, input logic g, input logic d);
        rst = r; req_fetch_req = q; eng_fetch_gnt = g; eng_fetch_done = d;
    endtask

    task automatic cyc_check();
        @(negedge clk);
        model_check();
    endtask

    task automatic cyc_end();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fixed_payloads();
        p_cmd[0] = 2'b01; p_tag[0] = 2'd2; p_addr[0] = 32'h1000;
        p_cmd[1] = 2'b00; p_tag[1] = 2'd1; p_addr[1] = 32'h2000;
        p_cmd[2] = 2'b01; p_tag[2] = 2'd3; p_addr[2] = 32'h3000;
    endtask

    typedef struct {
        logic          rst;
        logic [NR-1:0] req;
        logic          g;
        logic          d;
        logic          x_req;
        logic [NR-1:0] x_gnt;
        logic [NR-1:0] x_done;
        logic          x_busy;
        int            x_owner;
        logic [AW-1:0] x_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [NR-1:0] q, logic g, logic d, logic xr,
                                logic [NR-1:0] xg, logic [NR-1:0] xd, logic xb, int xo,
                                logic [AW-1:0] xa);
        vec_t v;
        v.rst = r; v.req = q; v.g = g; v.d = d; v.x_req = xr; v.x_gnt = xg;
        v.x_done = xd; v.x_busy = xb; v.x_owner = xo; v.x_addr = xa;
        return v;
    endfunction

    int rs [NR];

    initial begin
        for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
        set_fixed_payloads();
        drive(1, '0, 0, 0);
        @(posedge clk);
        #1;

        // Reset state.
        cyc_check();
        chk("reset_busy", arb_busy, 1'b0);
        chk("reset_eng_req", eng_fetch_req, 1'b0);
        chk("reset_owner", arb_owner, '0);
        chk("reset_payload", {eng_fetch_cmd, eng_fetch_tag, eng_fetch_addr}, '0);
        chk("reset_pulses", {req_fetch_gnt, req_fetch_done}, '0);
        cyc_end();

        //              rst req     g  d   ereq gnt     done    busy own addr
        // single request
        tbl.push_back(mk(0, 3'b001, 0, 0,  0, 3'b000, 3'b000, 0, 0, 32'h0));
        tbl.push_back(mk(0, 3'b001, 0, 0,  1, 3'b000, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b001, 0, 0,  1, 3'b000, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b001, 1, 0,  1, 3'b001, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b000, 0, 0,  0, 3'b000, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b000, 0, 0,  0, 3'b000, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b000, 0, 0,  0, 3'b000, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b000, 0, 1,  0, 3'b000, 3'b001, 1, 0, 32'h1000));
        tbl.push_back(mk(1, 3'b000, 0, 0,  0, 3'b000, 3'b000, 0, 0, 32'h1000));
        // contention from reset: 0 then 1
        tbl.push_back(mk(0, 3'b011, 0, 0,  0, 3'b000, 3'b000, 0, 0, 32'h0));
        tbl.push_back(mk(0, 3'b011, 1, 0,  1, 3'b001, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 0, 1,  0, 3'b000, 3'b001, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 0, 0,  0, 3'b000, 3'b000, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 1, 0,  1, 3'b010, 3'b000, 1, 1, 32'h2000));
        tbl.push_back(mk(0, 3'b000, 0, 1,  0, 3'b000, 3'b010, 1, 1, 32'h2000));
        // simultaneous again: search from 2 wraps to 0; done in ISSUE, gnt in BUSY ignored
        tbl.push_back(mk(0, 3'b011, 0, 0,  0, 3'b000, 3'b000, 0, 1, 32'h2000));
        tbl.push_back(mk(0, 3'b011, 0, 1,  1, 3'b000, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b011, 1, 0,  1, 3'b001, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 1, 0,  0, 3'b000, 3'b000, 1, 0, 32'h1000));
        // back-to-back: done at M, requester 1 issued at M+2
        tbl.push_back(mk(0, 3'b010, 0, 1,  0, 3'b000, 3'b001, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 0, 0,  0, 3'b000, 3'b000, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 1, 0,  1, 3'b010, 3'b000, 1, 1, 32'h2000));
        tbl.push_back(mk(0, 3'b000, 0, 1,  0, 3'b000, 3'b010, 1, 1, 32'h2000));
        tbl.push_back(mk(0, 3'b000, 0, 0,  0, 3'b000, 3'b000, 0, 1, 32'h2000));
        // requester 2, then pointer wraps back to 0
        tbl.push_back(mk(0, 3'b100, 0, 0,  0, 3'b000, 3'b000, 0, 1, 32'h2000));
        tbl.push_back(mk(0, 3'b100, 1, 0,  1, 3'b100, 3'b000, 1, 2, 32'h3000));
        tbl.push_back(mk(0, 3'b000, 0, 1,  0, 3'b000, 3'b100, 1, 2, 32'h3000));
        tbl.push_back(mk(0, 3'b011, 0, 0,  0, 3'b000, 3'b000, 0, 2, 32'h3000));
        tbl.push_back(mk(0, 3'b011, 1, 0,  1, 3'b001, 3'b000, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 0, 1,  0, 3'b000, 3'b001, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 0, 0,  0, 3'b000, 3'b000, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 3'b010, 1, 0,  1, 3'b010, 3'b000, 1, 1, 32'h2000));
        tbl.push_back(mk(0, 3'b000, 0, 1,  0, 3'b000, 3'b010, 1, 1, 32'h2000));
        tbl.push_back(mk(0, 3'b000, 0, 0,  0, 3'b000, 3'b000, 0, 1, 32'h2000));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].g, tbl[i].d);
            cyc_check();
            chk($sformatf("tbl%0d_eng_req", i), eng_fetch_req, tbl[i].x_req);
            chk($sformatf("tbl%0d_gnt", i), req_fetch_gnt, tbl[i].x_gnt);
            chk($sformatf("tbl%0d_done", i), req_fetch_done, tbl[i].x_done);
            chk($sformatf("tbl%0d_busy", i), arb_busy, tbl[i].x_busy);
            chk($sformatf("tbl%0d_owner", i), arb_owner, tbl[i].x_owner);
            chk($sformatf("tbl%0d_addr", i), eng_fetch_addr, tbl[i].x_addr);
            cyc_end();
        end

        // Isolation: requester 1 churns while requester 0 owns the engine.
        drive(1, 3'b000, 0, 0); cyc_check(); cyc_end();
        drive(0, 3'b001, 0, 0); cyc_check(); cyc_end();
        p_addr[1] = 32'h2222;
        drive(0, 3'b011, 0, 1); cyc_check();
        chk("iso_issue_done_ignored", req_fetch_done, 3'b000);
        chk("iso_issue_eng_req", eng_fetch_req, 1'b1);
        chk("iso_issue_addr", eng_fetch_addr, 32'h1000);
        cyc_end();
        drive(0, 3'b010, 1, 0); cyc_check();
        chk("iso_gnt0", req_fetch_gnt, 3'b001);
        cyc_end();
        for (int i = 0; i < 4; i++) begin
            p_addr[1] = $urandom;
            p_tag[1]  = TW'($urandom);
            drive(0, {1'b0, 1'(i % 2), 1'b0}, 1'(i == 2), 0);
            cyc_check();
            chk("iso_busy_addr", eng_fetch_addr, 32'h1000);
            chk("iso_busy_pulses", {req_fetch_gnt, req_fetch_done}, '0);
            chk("iso_busy_owner", arb_owner, 0);
            cyc_end();
        end
        p_addr[1] = 32'h2000;
        drive(0, 3'b010, 0, 1); cyc_check();
        chk("iso_done0", req_fetch_done, 3'b001);
        cyc_end();

        // Reset while requester 1 is BUSY.
        drive(0, 3'b010, 0, 0); cyc_check(); cyc_end();
        drive(0, 3'b010, 1, 0); cyc_check();
        chk("rstmid_gnt1", req_fetch_gnt, 3'b010);
        cyc_end();
        drive(1, 3'b000, 0, 1); cyc_check();
        chk("rstmid_no_done_in_rst", req_fetch_done, 3'b000);
        chk("rstmid_busy_before", arb_busy, 1'b1);
        cyc_end();
        drive(0, 3'b000, 0, 1); cyc_check();
        chk("rstmid_idle", arb_busy, 1'b0);
        chk("rstmid_eng_req", eng_fetch_req, 1'b0);
        chk("rstmid_owner", arb_owner, 0);
        chk("rstmid_no_done", req_fetch_done, 3'b000);
        cyc_end();
        drive(0, 3'b010, 0, 0); cyc_check(); cyc_end();
        drive(0, 3'b010, 1, 0); cyc_check();
        chk("rstmid_req1_first", arb_owner, 1);
        chk("rstmid_req1_addr", eng_fetch_addr, 32'h2000);
        chk("rstmid_req1_gnt", req_fetch_gnt, 3'b010);
        cyc_end();
        drive(0, 3'b000, 0, 1); cyc_check();
        chk("rstmid_req1_done", req_fetch_done, 3'b010);
        cyc_end();

        // Randomized traffic obeying the requester protocol, checked by the model.
        for (int i = 0; i < NR; i++) rs[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (rs[i] == 0 && $urandom_range(0, 3) == 0) rs[i] = 1;
                if (rs[i] != 1 || $urandom_range(0, 7) == 0 && !req_fetch_req[i]) begin
                    p_cmd[i]  = 2'($urandom_range(0, 1));
                    p_tag[i]  = TW'($urandom);
                    p_addr[i] = {$urandom, 6'b0} >> 0;
                end
            end
            begin
                logic [NR-1:0] q;
                for (int i = 0; i < NR; i++) q[i] = (rs[i] == 1);
                drive(($urandom_range(0, 299) == 0), q,
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            end
            cyc_check();
            for (int i = 0; i < NR; i++) begin
                if (rst) rs[i] = 0;
                else if (e_gnt[i]) rs[i] = 2;
                else if (e_done[i]) rs[i] = 0;
            end
            cyc_end();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
